// File: rtl/sdram_port_arbiter.sv
// SDRAM front end: power-up init sequencer, periodic refresh scheduler and two-port access arbiter.
// Build option SDRAM_ARB_RR_EN: round-robin between ports; when undefined, port 0 has fixed priority.
module sdram_port_arbiter #(
  parameter int ADDR_W           = 16,
  parameter int CYCLE_LEN        = 8,
  parameter int GAP_LEN          = 1,
  parameter int REFRESH_INTERVAL = 500,
  parameter int INIT_CLKS        = 16,
  parameter int INIT_CYCLES      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_ack,
  output logic              mem_init,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_refresh,
  output logic              mem_sel,
  output logic              ready
);

  localparam int CNT_MAX = (INIT_CLKS > CYCLE_LEN) ?
                           ((INIT_CLKS > GAP_LEN) ? INIT_CLKS : GAP_LEN) :
                           ((CYCLE_LEN > GAP_LEN) ? CYCLE_LEN : GAP_LEN);
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int PAIR_W = $clog2(INIT_CYCLES + 1);
  localparam int REF_W  = $clog2(REFRESH_INTERVAL + 1);

  localparam logic [CNT_W-1:0]  INIT_LAST  = CNT_W'(INIT_CLKS - 1);
  localparam logic [CNT_W-1:0]  CYCLE_LAST = CNT_W'(CYCLE_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST  = PAIR_W'(INIT_CYCLES - 1);
  localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_REF,
    S_INIT_GAP,
    S_IDLE,
    S_ACCESS,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PAIR_W-1:0]   r_pair;
  logic [REF_W-1:0]    r_ref_cnt;
  logic                r_ref_pend;
  logic                r_mem_init;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_ce;
  logic                r_mem_we;
  logic                r_mem_refresh;
  logic                r_mem_sel;
  logic                r_ready;
  logic                r_p0_ack;
  logic                r_p1_ack;
`ifdef SDRAM_ARB_RR_EN
  logic                r_last_grant;
`endif

  logic                w_ref_expire;
  logic                w_ref_start;
  logic                w_port_req;
  logic                w_grant;
  logic                w_grant_we;
  logic [ADDR_W-1:0]   w_grant_addr;

  // An expiry in the same clock as a port request already beats the port.
  assign w_ref_expire = r_ready && (r_ref_cnt == REF_LAST);
  assign w_ref_start  = (r_state == S_IDLE) && (r_ref_pend || w_ref_expire);
  assign w_port_req   = p0_req || p1_req;

`ifdef SDRAM_ARB_RR_EN
  assign w_grant = (p0_req && p1_req) ? ~r_last_grant : ~p0_req;
`else
  assign w_grant = ~p0_req;
`endif
  assign w_grant_we   = w_grant ? p1_we   : p0_we;
  assign w_grant_addr = w_grant ? p1_addr : p0_addr;

  // Free-running refresh interval timer; at most one refresh is ever pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else if (r_ready) begin
      r_ref_cnt <= w_ref_expire ? '0 : r_ref_cnt + 1'b1;
      if (w_ref_start)
        r_ref_pend <= r_ref_pend && w_ref_expire;
      else if (w_ref_expire)
        r_ref_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_INIT_WAIT;
      r_cnt         <= '0;
      r_pair        <= '0;
      r_mem_init    <= 1'b1;
      r_mem_addr    <= '0;
      r_mem_ce      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_refresh <= 1'b0;
      r_mem_sel     <= 1'b0;
      r_ready       <= 1'b0;
      r_p0_ack      <= 1'b0;
      r_p1_ack      <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      case (r_state)
        S_INIT_WAIT: begin
          if (r_cnt == INIT_LAST) begin
            r_cnt         <= '0;
            r_mem_init    <= 1'b0;
            r_mem_refresh <= 1'b1;
            r_state       <= S_INIT_REF;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_INIT_REF: begin
          if (r_cnt == CYCLE_LAST) begin
            r_cnt         <= '0;
            r_mem_refresh <= 1'b0;
            r_state       <= S_INIT_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_INIT_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (r_pair == PAIR_LAST) begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_pair        <= r_pair + 1'b1;
              r_mem_refresh <= 1'b1;
              r_state       <= S_INIT_REF;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_ref_start) begin
            r_mem_refresh <= 1'b1;
            r_mem_we      <= 1'b0;
            r_state       <= S_ACCESS;
          end else if (w_port_req) begin
            r_mem_ce   <= 1'b1;
            r_mem_we   <= w_grant_we;
            r_mem_addr <= w_grant_addr;
            r_mem_sel  <= w_grant;
`ifdef SDRAM_ARB_RR_EN
            r_last_grant <= w_grant;
`endif
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == CYCLE_LAST) begin
            r_cnt         <= '0;
            r_mem_ce      <= 1'b0;
            r_mem_refresh <= 1'b0;
            r_p0_ack      <= r_mem_ce && !r_mem_sel;
            r_p1_ack      <= r_mem_ce && r_mem_sel;
            r_state       <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_INIT_WAIT;
      endcase
    end
  end

  assign mem_init    = r_mem_init;
  assign mem_addr    = r_mem_addr;
  assign mem_ce      = r_mem_ce;
  assign mem_we      = r_mem_we;
  assign mem_refresh = r_mem_refresh;
  assign mem_sel     = r_mem_sel;
  assign ready       = r_ready;
  assign p0_ack      = r_p0_ack;
  assign p1_ack      = r_p1_ack;

endmodule
